// File: rtl/keypad_pkg.sv
// Shared key codes and debounce FSM state encoding for the keypad entry controller.
package keypad_pkg;

    localparam logic [4:0] KEY_NONE  = 5'd16;
    localparam logic [4:0] KEY_ENTER = 5'hE;
    localparam logic [4:0] KEY_CLEAR = 5'hF;
    localparam logic [4:0] KEY_BKSP  = 5'hD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEB  = 2'd1,
        ACT  = 2'd2,
        REL  = 2'd3
    } deb_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Press/release qualifier: one accept pulse per debounced press, then waits for full release.
// Accept fires after DEB_CNT same-code present samples; a held key never re-triggers.
import keypad_pkg::*;

module keypad_debounce #(
    parameter int DEB_CNT = 2,
    parameter int REL_CNT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] digito,
    input  logic       cambio_digito,
    output logic       accept,
    output logic [3:0] code
);

    localparam int CMAX = (DEB_CNT > REL_CNT) ? DEB_CNT : REL_CNT;
    localparam int CW   = $clog2(CMAX + 2);
    localparam logic [CW-1:0] DEB_LIM = CW'(DEB_CNT);
    localparam logic [CW-1:0] REL_LIM = CW'(REL_CNT);

    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;
    logic          present;

    // codes 16..31 on the 5-bit bus all mean "no key"
    assign present = cambio_digito && !digito[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (present) begin
                    state_d = DEB;
                    code_d  = digito[3:0];
                    cnt_d   = CW'(1);
                end
            end
            DEB: begin
                if (!present || (digito[3:0] != code_q)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if ((cnt_q + 1'b1) >= DEB_LIM) begin
                    state_d = ACT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACT: begin
                state_d = REL;
                cnt_d   = '0;
            end
            REL: begin
                if (present) begin
                    cnt_d = '0;
                end else if ((cnt_q + 1'b1) >= REL_LIM) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign accept = (state_q == ACT);
    assign code   = code_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry assembler: debounced keys build an NDIG-digit BCD entry, Enter hands it off over valid/ready.
// Entry is locked (keys discarded) while an entry is pending; optional backspace via KEYPAD_BACKSPACE_EN.
import keypad_pkg::*;

module keypad_entry_ctrl #(
    parameter  int NDIG    = 4,
    parameter  int DEB_CNT = 2,
    parameter  int REL_CNT = 2,
    localparam int CW      = $clog2(NDIG + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        digito,
    input  logic              cambio_digito,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [4*NDIG-1:0] out_value,
    output logic [CW-1:0]     out_ndig,
    output logic [4*NDIG-1:0] disp_value,
    output logic [CW-1:0]     disp_ndig,
    output logic              key_evt,
    output logic              err
);

    localparam logic [CW-1:0] FULL = CW'(NDIG);

    logic              accept;
    logic [3:0]        code;
    logic [4*NDIG-1:0] buf_q;
    logic [CW-1:0]     cnt_q;
    logic [4*NDIG+3:0] buf_ext;

    keypad_debounce #(
        .DEB_CNT (DEB_CNT),
        .REL_CNT (REL_CNT)
    ) u_debounce (
        .clk           (clk),
        .rst_n         (rst_n),
        .digito        (digito),
        .cambio_digito (cambio_digito),
        .accept        (accept),
        .code          (code)
    );

    // shift-in written via concatenation so NDIG=1 needs no special case
    assign buf_ext = {buf_q, code};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_value <= '0;
            out_ndig  <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // lock uses the current out_valid, so a key landing on the transfer cycle is dropped
            if (accept && !out_valid) begin
                if (is_digit(code)) begin
                    if (cnt_q < FULL) begin
                        buf_q <= buf_ext[4*NDIG-1:0];
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end else if (code == KEY_ENTER[3:0]) begin
                    if (cnt_q != '0) begin
                        out_value <= buf_q;
                        out_ndig  <= cnt_q;
                        out_valid <= 1'b1;
                        buf_q     <= '0;
                        cnt_q     <= '0;
                    end else begin
                        err <= 1'b1;
                    end
                end else if (code == KEY_CLEAR[3:0]) begin
                    buf_q <= '0;
                    cnt_q <= '0;
`ifdef KEYPAD_BACKSPACE_EN
                end else if (code == KEY_BKSP[3:0]) begin
                    if (cnt_q != '0) begin
                        buf_q <= buf_q >> 4;
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
`endif
                end
            end
        end
    end

    assign disp_value = buf_q;
    assign disp_ndig  = cnt_q;
    assign key_evt    = accept;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Randomized and directed bench for keypad_entry_ctrl against a digit-list reference model.
module tb_keypad_entry_ctrl;

    localparam int NDIG    = 4;
    localparam int DEB_CNT = 2;
    localparam int REL_CNT = 2;
    localparam int CW      = $clog2(NDIG + 1);

    logic              clk;
    logic              rst_n;
    logic [4:0]        digito;
    logic              cambio_digito;
    logic              out_ready;
    logic              out_valid;
    logic [4*NDIG-1:0] out_value;
    logic [CW-1:0]     out_ndig;
    logic [4*NDIG-1:0] disp_value;
    logic [CW-1:0]     disp_ndig;
    logic              key_evt;
    logic              err;

    keypad_entry_ctrl #(
        .NDIG    (NDIG),
        .DEB_CNT (DEB_CNT),
        .REL_CNT (REL_CNT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .digito        (digito),
        .cambio_digito (cambio_digito),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_value     (out_value),
        .out_ndig      (out_ndig),
        .disp_value    (disp_value),
        .disp_ndig     (disp_ndig),
        .key_evt       (key_evt),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int kev_cnt;
    int err_cnt;

    // reference model: entry as a list of digits, oldest first
    int digs[$];
    bit pend;
    int pend_val;
    int pend_n;
    int exp_kev;
    int exp_err;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int entry_value();
        int v = 0;
        foreach (digs[i]) v = v * 16 + digs[i];
        return v;
    endfunction

    task automatic model_key(input int c);
        exp_kev = 1;
        if (pend) return;
        if (c <= 9) begin
            if (digs.size() < NDIG) digs.push_back(c);
            else exp_err = 1;
        end else if (c == 14) begin
            if (digs.size() > 0) begin
                pend     = 1'b1;
                pend_val = entry_value();
                pend_n   = digs.size();
                digs.delete();
            end else begin
                exp_err = 1;
            end
        end else if (c == 15) begin
            digs.delete();
`ifdef KEYPAD_BACKSPACE_EN
        end else if (c == 13) begin
            if (digs.size() > 0) void'(digs.pop_back());
            else exp_err = 1;
`endif
        end
    endtask

    task automatic model_reset();
        digs.delete();
        pend     = 1'b0;
        pend_val = 0;
        pend_n   = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (key_evt) kev_cnt++;
        if (err) err_cnt++;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_disp"}, disp_value, entry_value());
        check({tag, "_dndig"}, disp_ndig, digs.size());
        check({tag, "_vld"}, out_valid, pend);
        if (pend) begin
            check({tag, "_oval"}, out_value, pend_val);
            check({tag, "_ondig"}, out_ndig, pend_n);
        end
    endtask

    // present for len samples, then gap absent samples with noise on digito
    task automatic press(input int code, input int len, input int gap);
        kev_cnt = 0;
        err_cnt = 0;
        exp_kev = 0;
        exp_err = 0;
        cambio_digito = 1'b1;
        digito = 5'(code);
        repeat (len) tick();
        cambio_digito = 1'b0;
        for (int i = 0; i < gap; i++) begin
            digito = 5'($urandom_range(0, 31));
            tick();
        end
        digito = 5'd16;
        if (len >= DEB_CNT) model_key(code);
        check("kev", kev_cnt, exp_kev);
        check("err", err_cnt, exp_err);
        check_state("key");
    endtask

    task automatic key(input int code);
        press(code, 3, 3);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        pend = 1'b0;
        check("drain_vld", out_valid, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_vld"}, out_valid, 1'b0);
        check({tag, "_oval"}, out_value, 0);
        check({tag, "_ondig"}, out_ndig, 0);
        check({tag, "_disp"}, disp_value, 0);
        check({tag, "_dndig"}, disp_ndig, 0);
        check({tag, "_kev"}, key_evt, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        digito        = 5'd16;
        cambio_digito = 1'b0;
        out_ready     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1,2,3 then Enter and accept
        key(1); key(2); key(3); key(14);
        check("e123_val", out_value, 32'h0123);
        check("e123_n", out_ndig, 3);
        drain();

        // single-sample press is rejected
        press(5, 1, 3);
        check("short_ndig", disp_ndig, 0);

        // overflow: fifth digit errors once
        key(9); key(8); key(7); key(6); key(5);
        check("full_disp", disp_value, 32'h9876);
        key(15);

        // Enter on empty, Clear after 4,2
        key(14);
        key(4); key(2); key(15);

        // pending entry held under back-pressure, 7 discarded
        key(3); key(14);
        repeat (10) tick();
        check("hold_val", out_value, 32'h0003);
        key(7);
        check("hold_disp", disp_value, 0);
        drain();
        drain();

`ifdef KEYPAD_BACKSPACE_EN
        key(1); key(2); key(13);
        check("bksp_disp", disp_value, 32'h0001);
        key(13); key(13);
        key(15);
`else
        key(1); key(13);
        check("d_ignored", disp_value, 32'h0001);
        key(15);
`endif

        // randomized presses with occasional draining
        for (int n = 0; n < 60; n++) begin
            int r, c;
            r = $urandom_range(0, 19);
            if (r < 12) c = $urandom_range(0, 9);
            else if (r < 14) c = 14;
            else if (r < 15) c = 15;
            else c = 10 + $urandom_range(0, 3);
            press(c, ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(3, 5), $urandom_range(3, 5));
            if ($urandom_range(0, 3) == 0) drain();
        end

        // asynchronous reset while debouncing
        key(6);
        cambio_digito = 1'b1;
        digito = 5'd4;
        tick();
        #2 rst_n = 1'b0;
        #1 check_zero("rst_deb");
        cambio_digito = 1'b0;
        digito = 5'd16;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();

        // asynchronous reset with an entry pending
        key(5); key(14);
        check("pre_rst_vld", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_zero("rst_pend");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        key(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
